// File: rtl/sort_result_serializer.sv
// Output stage of Core-Sort: buffers one sorted vector and streams it out one element per beat,
// in ascending or descending emission order, with a sticky monotonicity check on the emitted stream.
module sort_result_serializer #(
    parameter int SIZE_DATA = 8,
    parameter int NUM_DATA  = 8,
    parameter int IDX_W     = $clog2(NUM_DATA)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_vec_valid,
    output logic                          o_vec_ready,
    input  logic [NUM_DATA*SIZE_DATA-1:0] i_vec_data,
    input  logic                          i_desc,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [SIZE_DATA-1:0]          o_data,
    output logic [IDX_W-1:0]              o_index,
    output logic                          o_last,
    output logic                          o_order_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DATA - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [SIZE_DATA-1:0] buffer [NUM_DATA];
    logic                 desc;
    logic                 first;
    logic [IDX_W-1:0]     index;
    logic [SIZE_DATA-1:0] prev;
    logic                 order_err;
    logic                 accept;
    logic                 transfer;
    logic                 violation;

    assign o_vec_ready = (state == IDLE) && !i_rst;
    assign o_valid     = (state == SEND);
    assign o_data      = buffer[index];
    assign o_index     = index;
    assign o_last      = (state == SEND) && (desc ? (index == '0) : (index == LAST_IDX));
    assign o_order_err = order_err;

    assign accept   = i_vec_valid && o_vec_ready;
    assign transfer = o_valid && i_ready;

    // The first beat of a vector has no predecessor, so it can never violate the ordering.
    assign violation = !first && (desc ? (o_data > prev) : (o_data < prev));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = SEND;
            SEND: if (transfer && o_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            desc      <= 1'b0;
            first     <= 1'b0;
            index     <= '0;
            prev      <= '0;
            order_err <= 1'b0;
            for (int k = 0; k < NUM_DATA; k++) begin
                buffer[k] <= '0;
            end
        end else begin
            state <= state_next;
            if (accept) begin
                for (int k = 0; k < NUM_DATA; k++) begin
                    buffer[k] <= i_vec_data[k*SIZE_DATA +: SIZE_DATA];
                end
                desc      <= i_desc;
                index     <= i_desc ? LAST_IDX : '0;
                first     <= 1'b1;
                order_err <= 1'b0;
            end else if (transfer) begin
                prev  <= o_data;
                first <= 1'b0;
                if (violation) begin
                    order_err <= 1'b1;
                end
                // Index parks on the final element after the last beat.
                if (!o_last) begin
                    index <= desc ? (index - 1'b1) : (index + 1'b1);
                end
            end
        end
    end

endmodule
